// File: rtl/wb_display_monitor.sv
// Shadows the writeback bus and shows one register on the HEX displays.
// KEYs (active-low, debounced) select, freeze and clear the write count.
//
// Ports:
//   I_CLOCK, I_RESET_N   clock, async active-low reset
//   I_LOCK               pipeline running; gates capture and counting
//   I_WriteBack*         writeback valid / destination index / data
//   I_KEY[3:0]           raw pushbuttons: 0 clr, 1 sel+, 2 sel-, 3 freeze
//   O_DispValue          registered value of the selected shadow register
//   O_DispRegIdx         selected register
//   O_Frozen             display held
//   O_WriteCount         saturating count of accepted writebacks
module wb_display_monitor #(
  parameter int REG_WIDTH       = 16,
  parameter int NUM_REGS        = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET_N,
  input  logic                 I_LOCK,
  input  logic                 I_WriteBackEnable,
  input  logic [3:0]           I_WriteBackRegIdx,
  input  logic [REG_WIDTH-1:0] I_WriteBackData,
  input  logic [3:0]           I_KEY,
  output logic [REG_WIDTH-1:0] O_DispValue,
  output logic [3:0]           O_DispRegIdx,
  output logic                 O_Frozen,
  output logic [15:0]          O_WriteCount
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {LIVE, FROZEN} state_e;

  state_e state_q, state_d;

  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           deb_q, deb_d;
  logic [3:0]           press;
  logic [CW-1:0]        cnt_q [4];
  logic [CW-1:0]        cnt_d [4];
  logic [REG_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [3:0]           sel_q, sel_d;
  logic [REG_WIDTH-1:0] disp_q, disp_d;
  logic [15:0]          wcnt_q, wcnt_d;
  logic [REG_WIDTH-1:0] next_val;
  logic                 wr;

  assign wr = I_LOCK & I_WriteBackEnable;

  // A press fires on the edge the debounced level falls 1->0.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      deb_d[k] = deb_q[k];
      cnt_d[k] = '0;
      press[k] = 1'b0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          deb_d[k] = sync2_q[k];
          press[k] = deb_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q <= I_KEY;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (wr) begin
      shadow_q[I_WriteBackRegIdx] <= I_WriteBackData;
    end
  end

  // Bypass the same-cycle write so LIVE shows it one edge later.
  always_comb begin
    sel_d = sel_q;
    unique case (1'b1)
      press[1] & ~press[2]: sel_d = sel_q + 4'd1;
      press[2] & ~press[1]: sel_d = sel_q - 4'd1;
      default:              sel_d = sel_q;
    endcase
    if (wr && I_WriteBackRegIdx == sel_d) next_val = I_WriteBackData;
    else                                  next_val = shadow_q[sel_d];
  end

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    if (press[3]) state_d = (state_q == LIVE) ? FROZEN : LIVE;
    unique case (state_q)
      LIVE:    disp_d = next_val;
      FROZEN:  if (sel_d != sel_q) disp_d = next_val;
      default: disp_d = disp_q;
    endcase
  end

  // Clear beats a simultaneous increment.
  always_comb begin
    wcnt_d = wcnt_q;
    if (press[0])                     wcnt_d = '0;
    else if (wr && wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= LIVE;
      sel_q   <= '0;
      disp_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      disp_q  <= disp_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign O_DispValue  = disp_q;
  assign O_DispRegIdx = sel_q;
  assign O_Frozen     = (state_q == FROZEN);
  assign O_WriteCount = wcnt_q;

endmodule

// File: tb/tb_wb_display_monitor.sv
// Bench for wb_display_monitor: scoreboard of expected outputs,
// one task per scenario.
module tb_wb_display_monitor;

  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock;
  logic        we;
  logic [3:0]  widx;
  logic [15:0] wdata;
  logic [3:0]  key;
  logic [15:0] disp;
  logic [3:0]  sel;
  logic        frz;
  logic [15:0] wcnt;

  logic [15:0] sb [$];
  logic [15:0] e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_sh [16];
  int          m_sel = 0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  wb_display_monitor #(
    .REG_WIDTH(16), .NUM_REGS(16), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .I_CLOCK(clk),
    .I_RESET_N(rst_n),
    .I_LOCK(lock),
    .I_WriteBackEnable(we),
    .I_WriteBackRegIdx(widx),
    .I_WriteBackData(wdata),
    .I_KEY(key),
    .O_DispValue(disp),
    .O_DispRegIdx(sel),
    .O_Frozen(frz),
    .O_WriteCount(wcnt)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int k);
    key[k] = 1'b0;
    tick(DEB + 6);
    key[k] = 1'b1;
    tick(DEB + 6);
  endtask

  task automatic write_reg(input logic [3:0] i, input logic [15:0] d);
    we = 1'b1; widx = i; wdata = d;
    tick(1);
    we = 1'b0;
    if (lock) begin
      m_sh[i] = d;
      m_cnt++;
    end
  endtask

  task automatic test_reset;
    sb.push_back(16'h0); sb.push_back(16'h0);
    sb.push_back(16'h0); sb.push_back(16'h0);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL reset_disp got %h want %h", disp, e); end
    e = sb.pop_front(); n_vec++;
    if ({12'h0, sel} !== e) begin n_err++; $display("FAIL reset_sel got %h want %h", sel, e); end
    e = sb.pop_front(); n_vec++;
    if ({15'h0, frz} !== e) begin n_err++; $display("FAIL reset_frozen got %h want %h", frz, e); end
    e = sb.pop_front(); n_vec++;
    if (wcnt !== e) begin n_err++; $display("FAIL reset_count got %h want %h", wcnt, e); end
  endtask

  task automatic test_capture;
    write_reg(4'd3, 16'h1234);
    sb.push_back(m_sh[m_sel]); sb.push_back(16'(m_cnt));
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t1_disp got %h want %h", disp, e); end
    e = sb.pop_front(); n_vec++;
    if (wcnt !== e) begin n_err++; $display("FAIL t1_count got %h want %h", wcnt, e); end
  endtask

  task automatic test_select;
    repeat (3) begin press_key(1); m_sel = (m_sel + 1) % 16; end
    sb.push_back(16'(m_sel)); sb.push_back(m_sh[m_sel]);
    e = sb.pop_front(); n_vec++;
    if ({12'h0, sel} !== e) begin n_err++; $display("FAIL t2_sel_up got %h want %h", sel, e); end
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t2_disp got %h want %h", disp, e); end
    repeat (4) begin press_key(2); m_sel = (m_sel + 15) % 16; end
    sb.push_back(16'(m_sel));
    e = sb.pop_front(); n_vec++;
    if ({12'h0, sel} !== e) begin n_err++; $display("FAIL t2_sel_wrap got %h want %h", sel, e); end
  endtask

  task automatic test_live;
    repeat (4) begin press_key(1); m_sel = (m_sel + 1) % 16; end
    we = 1'b1; widx = 4'd3; wdata = 16'hBEEF;
    sb.push_back(m_sh[3]);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t3_before got %h want %h", disp, e); end
    tick(1);
    we = 1'b0; m_sh[3] = 16'hBEEF; m_cnt++;
    sb.push_back(m_sh[m_sel]);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t3_after got %h want %h", disp, e); end
  endtask

  task automatic test_freeze;
    bit hit;
    press_key(3);
    write_reg(4'd3, 16'h0001);
    sb.push_back(16'h1); sb.push_back(16'hBEEF); sb.push_back(16'(m_cnt));
    e = sb.pop_front(); n_vec++;
    if ({15'h0, frz} !== e) begin n_err++; $display("FAIL t4_frozen got %h want %h", frz, e); end
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t4_hold got %h want %h", disp, e); end
    e = sb.pop_front(); n_vec++;
    if (wcnt !== e) begin n_err++; $display("FAIL t4_count got %h want %h", wcnt, e); end
    key[3] = 1'b0;
    hit = 0;
    for (int i = 0; i < DEB + 10; i++) begin
      tick(1);
      if (frz == 1'b0) begin hit = 1; break; end
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL t4_unfreeze_timeout got %b want 0", frz); end
    sb.push_back(16'hBEEF);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t4_toggle_edge got %h want %h", disp, e); end
    tick(1);
    sb.push_back(16'h0001);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t4_resume got %h want %h", disp, e); end
    key[3] = 1'b1;
    tick(DEB + 6);
    press_key(3);
    write_reg(4'd2, 16'h2222);
    press_key(2); m_sel = 2;
    sb.push_back(16'h2222);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t4_frz_sel got %h want %h", disp, e); end
    write_reg(4'd2, 16'h3333);
    sb.push_back(16'h2222);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t4_frz_reheld got %h want %h", disp, e); end
    press_key(3);
    sb.push_back(16'h3333);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t4_live_again got %h want %h", disp, e); end
    press_key(1); m_sel = 3;
  endtask

  task automatic test_glitch;
    key[1] = 1'b0;
    tick(DEB - 1);
    key[1] = 1'b1;
    tick(DEB + 6);
    sb.push_back(16'(m_sel));
    e = sb.pop_front(); n_vec++;
    if ({12'h0, sel} !== e) begin n_err++; $display("FAIL t5_glitch got %h want %h", sel, e); end
    key[1] = 1'b0; key[2] = 1'b0;
    tick(DEB + 6);
    key[1] = 1'b1; key[2] = 1'b1;
    tick(DEB + 6);
    sb.push_back(16'(m_sel));
    e = sb.pop_front(); n_vec++;
    if ({12'h0, sel} !== e) begin n_err++; $display("FAIL t5_both got %h want %h", sel, e); end
  endtask

  task automatic test_lock_clear;
    bit hit;
    logic [15:0] prev;
    lock = 1'b0;
    write_reg(4'd3, 16'hAAAA);
    sb.push_back(m_sh[3]); sb.push_back(16'(m_cnt));
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t6_nolock_disp got %h want %h", disp, e); end
    e = sb.pop_front(); n_vec++;
    if (wcnt !== e) begin n_err++; $display("FAIL t6_nolock_count got %h want %h", wcnt, e); end
    lock = 1'b1;
    we = 1'b1; widx = 4'd5; wdata = 16'h5555;
    key[0] = 1'b0;
    prev = wcnt;
    hit = 0;
    for (int i = 0; i < DEB + 10; i++) begin
      tick(1);
      if (wcnt < prev) begin hit = 1; break; end
      prev = wcnt;
    end
    n_vec++;
    if (!hit) begin n_err++; $display("FAIL t6_clear_timeout got %h want 0", wcnt); end
    sb.push_back(16'h0);
    e = sb.pop_front(); n_vec++;
    if (wcnt !== e) begin n_err++; $display("FAIL t6_clear got %h want %h", wcnt, e); end
    tick(1);
    we = 1'b0;
    sb.push_back(16'h1);
    e = sb.pop_front(); n_vec++;
    if (wcnt !== e) begin n_err++; $display("FAIL t6_after_clear got %h want %h", wcnt, e); end
    key[0] = 1'b1;
    tick(DEB + 6);
  endtask

  task automatic test_reset_mid;
    press_key(3);
    key[1] = 1'b0;
    tick(8);
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(16'h0); sb.push_back(16'h0);
    sb.push_back(16'h0); sb.push_back(16'h0);
    e = sb.pop_front(); n_vec++;
    if (disp !== e) begin n_err++; $display("FAIL t6_rst_disp got %h want %h", disp, e); end
    e = sb.pop_front(); n_vec++;
    if ({12'h0, sel} !== e) begin n_err++; $display("FAIL t6_rst_sel got %h want %h", sel, e); end
    e = sb.pop_front(); n_vec++;
    if ({15'h0, frz} !== e) begin n_err++; $display("FAIL t6_rst_frozen got %h want %h", frz, e); end
    e = sb.pop_front(); n_vec++;
    if (wcnt !== e) begin n_err++; $display("FAIL t6_rst_count got %h want %h", wcnt, e); end
    key[1] = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(DEB + 6);
    sb.push_back(16'h0);
    e = sb.pop_front(); n_vec++;
    if ({12'h0, sel} !== e) begin n_err++; $display("FAIL t6_post_sel got %h want %h", sel, e); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_sh[i] = 16'h0;
    rst_n = 1'b0; lock = 1'b0; we = 1'b0;
    widx = 4'd0; wdata = 16'h0; key = 4'hF;
    tick(3);
    test_reset;
    rst_n = 1'b1;
    lock = 1'b1;
    tick(1);
    test_capture;
    test_select;
    test_live;
    test_freeze;
    test_glitch;
    test_lock_clear;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
